cmp_arbiter: RTL

Sequencer and two-way arbiter for the shared branch comparator. It accepts branch-resolution requests from the decode/execute stage and set-less-than (SLT/SLTU) requests from the ALU. It grants one request at a time, drives the comparator's `cmpop`/`rs1_out`/`rs2_out` inputs from registered operands, and captures `br_eq`/`br_lt`. It returns a one-cycle registered response to the winning requester: taken/target for branches, 0/1 word for SLT.

---
 rtl/cmp_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cmp_arbiter.sv
// Arbiter and sequencer for the shared branch comparator (branch vs SLT/SLTU requesters).
// Optional CMP_ARB_FIXED_PRIO_EN: branch always wins ties and no last-grant state is kept.
module cmp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_req_valid,
  output logic             br_req_ready,
  input  logic [2:0]       br_funct3,
  input  logic [WIDTH-1:0] br_rs1,
  input  logic [WIDTH-1:0] br_rs2,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_imm,
  output logic             br_resp_valid,
  output logic             br_taken,
  output logic             br_illegal,
  output logic [WIDTH-1:0] br_target,
  input  logic             slt_req_valid,
  output logic             slt_req_ready,
  input  logic             slt_unsigned,
  input  logic [WIDTH-1:0] slt_a,
  input  logic [WIDTH-1:0] slt_b,
  output logic             slt_resp_valid,
  output logic [WIDTH-1:0] slt_result,
  output logic             cmpop,
  output logic [WIDTH-1:0] rs1_out,
  output logic [WIDTH-1:0] rs2_out,
  input  logic             br_eq,
  input  logic             br_lt
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  state_t           state_reg, state_next;
  logic             can_grant, grant_br, grant_slt;
  logic [WIDTH-1:0] op_a_reg, op_b_reg, pc_reg, imm_reg;
  logic             op_signed_reg, op_is_br_reg;
  logic [2:0]       funct3_reg;
  logic             taken_c, illegal_c;

  logic             br_resp_valid_reg, br_taken_reg, br_illegal_reg, slt_resp_valid_reg;
  logic [WIDTH-1:0] br_target_reg, slt_result_reg;

  assign can_grant = !rst && (state_reg != CMP);

`ifdef CMP_ARB_FIXED_PRIO_EN
  assign grant_br  = can_grant && br_req_valid;
  assign grant_slt = can_grant && slt_req_valid && !br_req_valid;
`else
  logic last_slt_reg;  // 1 = SLT was granted last; reset to SLT so the branch wins the first tie

  assign grant_br  = can_grant && br_req_valid && (!slt_req_valid || last_slt_reg);
  assign grant_slt = can_grant && slt_req_valid && (!br_req_valid || !last_slt_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_slt_reg <= 1'b1;
    end else if (grant_br) begin
      last_slt_reg <= 1'b0;
    end else if (grant_slt) begin
      last_slt_reg <= 1'b1;
    end
  end
`endif

  assign br_req_ready  = grant_br;
  assign slt_req_ready = grant_slt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmpop      = 1'b0;
    rs1_out    = '0;
    rs2_out    = '0;
    case (state_reg)
      IDLE: if (grant_br || grant_slt) state_next = CMP;
      CMP: begin
        state_next = DONE;
        cmpop      = op_signed_reg;
        rs1_out    = op_a_reg;
        rs2_out    = op_b_reg;
      end
      DONE: state_next = (grant_br || grant_slt) ? CMP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      pc_reg        <= '0;
      imm_reg       <= '0;
      funct3_reg    <= '0;
      op_signed_reg <= 1'b0;
      op_is_br_reg  <= 1'b0;
    end else if (grant_br) begin
      op_a_reg      <= br_rs1;
      op_b_reg      <= br_rs2;
      pc_reg        <= br_pc;
      imm_reg       <= br_imm;
      funct3_reg    <= br_funct3;
      op_signed_reg <= ~br_funct3[1];
      op_is_br_reg  <= 1'b1;
    end else if (grant_slt) begin
      op_a_reg      <= slt_a;
      op_b_reg      <= slt_b;
      op_signed_reg <= ~slt_unsigned;
      op_is_br_reg  <= 1'b0;
    end
  end

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (funct3_reg)
      3'b000:          taken_c = br_eq;
      3'b001:          taken_c = ~br_eq;
      3'b100, 3'b110:  taken_c = br_lt;
      3'b101, 3'b111:  taken_c = ~br_lt;
      default:         illegal_c = 1'b1;
    endcase
  end

  // Response data is only rewritten for the requester being answered; the rest holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_resp_valid_reg  <= 1'b0;
      br_taken_reg       <= 1'b0;
      br_illegal_reg     <= 1'b0;
      br_target_reg      <= '0;
      slt_resp_valid_reg <= 1'b0;
      slt_result_reg     <= '0;
    end else begin
      br_resp_valid_reg  <= 1'b0;
      slt_resp_valid_reg <= 1'b0;
      if (state_reg == CMP) begin
        if (op_is_br_reg) begin
          br_resp_valid_reg <= 1'b1;
          br_taken_reg      <= taken_c;
          br_illegal_reg    <= illegal_c;
          br_target_reg     <= taken_c ? (pc_reg + imm_reg) : (pc_reg + PC_STEP);
        end else begin
          slt_resp_valid_reg <= 1'b1;
          slt_result_reg     <= {{(WIDTH-1){1'b0}}, br_lt};
        end
      end
    end
  end

  assign br_resp_valid  = br_resp_valid_reg;
  assign br_taken       = br_taken_reg;
  assign br_illegal     = br_illegal_reg;
  assign br_target      = br_target_reg;
  assign slt_resp_valid = slt_resp_valid_reg;
  assign slt_result     = slt_result_reg;

endmodule
